// File: rtl/window_buffer.sv
// window_buffer: streaming WIN_H x WIN_W neighbourhood generator over a raster pixel stream
//   clk, rst              rising-edge clock, synchronous active-high reset
//   data_i                pixel, channel n at [n*COLORDEPTH +: COLORDEPTH]
//   dv_i, hs_i, vs_i      data valid, hsync, vsync (rising vs_i = frame start)
//   dv_o, hs_o, vs_o      syncs delayed by 2 cycles, aligned with win_o
//   win_o                 element [r][c] at ((r*WIN_W)+c)*PW, r=0 newest line, c=0 newest pixel
//   win_valid_o           every window element is a real pixel of the current frame
//   Optional: WINBUF_BORDER_REPLICATE_EN replicates the oldest valid line into rows
//   not yet filled this frame; otherwise those rows read as 0.
module window_buffer #(
  parameter int COLORDEPTH  = 11,
  parameter int CHANNELS    = 1,
  parameter int SCREENWIDTH = 25,
  parameter int WIN_H       = 5,
  parameter int WIN_W       = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [CHANNELS*COLORDEPTH-1:0]                data_i,
  input  logic                                          dv_i,
  input  logic                                          hs_i,
  input  logic                                          vs_i,
  output logic                                          dv_o,
  output logic                                          hs_o,
  output logic                                          vs_o,
  output logic [WIN_H*WIN_W*CHANNELS*COLORDEPTH-1:0]    win_o,
  output logic                                          win_valid_o
);
  localparam int PW = CHANNELS * COLORDEPTH;
  localparam int RW = WIN_W * PW;
  localparam int AW = SCREENWIDTH > 1 ? $clog2(SCREENWIDTH) : 1;
  localparam int LW = $clog2(WIN_H);
  logic [AW-1:0] col_cnt, a1;
  logic [LW-1:0] line_cnt, lc2;
  logic [PW-1:0] d1;
  logic v1, hs1, vs1, armed, vs_rise, dv_fall;
  logic [WIN_H*PW-1:0] col;
  logic [WIN_H*RW-1:0] win_q, win_d;
  assign vs_rise = vs_i & ~vs1;
  assign dv_fall = ~dv_i & v1;
  // armed keeps win_valid_o low after reset until a real frame start is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt     <= '0;
      line_cnt    <= '0;
      armed       <= 1'b0;
      v1          <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      d1          <= '0;
      a1          <= '0;
      dv_o        <= 1'b0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      win_q       <= '0;
      lc2         <= '0;
      win_valid_o <= 1'b0;
    end else begin
      col_cnt     <= !dv_i ? '0 : col_cnt == AW'(SCREENWIDTH - 1) ? '0 : col_cnt + 1'b1;
      line_cnt    <= vs_rise ? '0 : (dv_fall && line_cnt != LW'(WIN_H - 1)) ? line_cnt + 1'b1 : line_cnt;
      armed       <= armed | vs_rise;
      v1          <= dv_i;
      hs1         <= hs_i;
      vs1         <= vs_i;
      d1          <= data_i;
      a1          <= col_cnt;
      dv_o        <= v1;
      hs_o        <= hs1;
      vs_o        <= vs1;
      win_valid_o <= v1 && armed && line_cnt == LW'(WIN_H - 1) && int'(a1) >= WIN_W - 1;
      if (v1) begin
        win_q <= win_d;
        lc2   <= line_cnt;
      end
    end
  end
  assign col[PW-1:0] = d1;
  // line k holds the line k rows back; each write pushes the column one line further down
  for (genvar k = 1; k < WIN_H; k++) begin : g_line
    logic [PW-1:0] mem [SCREENWIDTH];
    logic [PW-1:0] rd;
    always_ff @(posedge clk) begin
      rd <= mem[col_cnt];
      if (v1) mem[a1] <= col[(k-1)*PW +: PW];
    end
    assign col[k*PW +: PW] = rd;
  end
  // each row shifts one column older; the fresh column vector enters at column 0
  always_comb begin
    win_d = '0;
    for (int r = 0; r < WIN_H; r++)
      win_d[r*RW +: RW] = RW'({win_q[r*RW +: RW], col[r*PW +: PW]});
  end
  always_comb begin
    win_o = '0;
    for (int r = 0; r < WIN_H; r++)
`ifdef WINBUF_BORDER_REPLICATE_EN
      win_o[r*RW +: RW] = win_q[(r > int'(lc2) ? int'(lc2) : r)*RW +: RW];
`else
      win_o[r*RW +: RW] = r > int'(lc2) ? '0 : win_q[r*RW +: RW];
`endif
  end
endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: randomized and ramp-driven checks of window_buffer against a frame-image model
module tb_window_buffer;
  localparam int CD = 11, CH = 3, SW = 25, WH = 5, WW = 3;
  localparam int PW = CD * CH, WN = WH * WW;
  logic clk = 1'b0, rst = 1'b1, dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [PW-1:0] data_i = '0;
  logic dv_o, hs_o, vs_o, win_valid_o;
  logic [WN*PW-1:0] win_o;
  always #5 clk = ~clk;
  window_buffer #(.COLORDEPTH(CD), .CHANNELS(CH), .SCREENWIDTH(SW), .WIN_H(WH), .WIN_W(WW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .win_o(win_o), .win_valid_o(win_valid_o));
  typedef struct {
    logic dv, hs, vs, vld;
    logic [WN*PW-1:0] w, m;
    int line, col;
  } exp_t;
  exp_t q[$];
  exp_t last;
  int ntests = 0, nfail = 0;
  logic [PW-1:0] img [8][SW];
  int gl = 8, col = 0, fl = 0, fline = 0;
  bit armed = 0, p_dv = 0, p_vs = 0;
  int probe_l = -1, probe_c = -1, first_l = -1, first_c = -1;
  bit snap_hit = 0;
  logic [WN*PW-1:0] snap_w;
  logic snap_v;
  int vcnt [16];
  function automatic logic [PW-1:0] ramp(input int l, input int c);
    logic [PW-1:0] p;
    for (int n = 0; n < CH; n++) p[n*CD +: CD] = CD'(l * 32 + c + n * 512);
    return p;
  endfunction
  function automatic logic [PW-1:0] elem(input logic [WN*PW-1:0] w, input int r, input int k);
    return w[(r*WW+k)*PW +: PW];
  endfunction
  task automatic model_reset();
    q.delete();
    col = 0; fl = 0; fline = 0; armed = 0; p_dv = 0; p_vs = 0;
    last.dv = 0; last.hs = 0; last.vs = 0; last.vld = 0;
    last.w = '0; last.m = '1; last.line = -1; last.col = -1;
    q.push_back(last);
  endtask
  task automatic step(input logic d, input logic h, input logic v, input logic [PW-1:0] px);
    exp_t e, got;
    int s;
    dv_i = d; hs_i = h; vs_i = v; data_i = px;
    if (!d && p_dv) gl++;
    if (v && !p_vs) begin fl = 0; fline = 0; armed = 1; end
    else if (!d && p_dv) begin fl = fl < WH - 1 ? fl + 1 : fl; fline++; end
    if (!d) col = 0;
    e = last; e.vld = 0; e.line = -1; e.col = -1;
    if (d) begin
      img[gl % 8][col] = px;
      e.w = '0; e.m = '0; e.line = fline; e.col = col;
      for (int r = 0; r < WH; r++)
        for (int k = 0; k < WW; k++) begin
          s = r > fl ? fl : r;
`ifndef WINBUF_BORDER_REPLICATE_EN
          if (r > fl) e.m[(r*WW+k)*PW +: PW] = '1; else
`endif
          if ((s == 0 || armed) && col >= k) begin
            e.w[(r*WW+k)*PW +: PW] = img[(gl - s) % 8][col - k];
            e.m[(r*WW+k)*PW +: PW] = '1;
          end
        end
      e.vld = armed && fl == WH - 1 && col >= WW - 1;
      col = col == SW - 1 ? 0 : col + 1;
      last = e;
    end
    e.dv = d; e.hs = h; e.vs = v;
    p_dv = d; p_vs = v;
    q.push_back(e);
    @(posedge clk); #1;
    got = q.pop_front();
    ntests += 3;
    if ({dv_o, hs_o, vs_o} !== {got.dv, got.hs, got.vs}) begin
      nfail++; $display("FAIL syncs: got %b%b%b want %b%b%b", dv_o, hs_o, vs_o, got.dv, got.hs, got.vs);
    end
    if (win_valid_o !== got.vld) begin
      nfail++; $display("FAIL win_valid line %0d col %0d: got %b want %b", got.line, got.col, win_valid_o, got.vld);
    end
    if (((win_o ^ got.w) & got.m) !== '0) begin
      nfail++; $display("FAIL window line %0d col %0d: got %h want %h mask %h", got.line, got.col, win_o, got.w, got.m);
    end
    if (got.dv && got.line == probe_l && got.col == probe_c && !snap_hit) begin
      snap_hit = 1; snap_w = win_o; snap_v = win_valid_o;
    end
    if (win_valid_o && first_l < 0) begin first_l = got.line; first_c = got.col; end
    if (win_valid_o && got.line >= 0 && got.line < 16) vcnt[got.line]++;
  endtask
  task automatic drive_vs();
    step(0, 0, 1, '0); step(0, 0, 1, '0); step(0, 0, 0, '0); step(0, 0, 0, '0);
  endtask
  task automatic drive_lines(input int n, input int len, input bit rnd);
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < len; c++) step(1, 0, 0, rnd ? PW'({$urandom, $urandom}) : ramp(l, c));
      for (int b = 0; b < 6; b++) step(0, b >= 1 && b < 3, 0, '0);
    end
  endtask
  task automatic test_reset();
    logic h [20];
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      dv_i = 1'($urandom); hs_i = 1'($urandom); vs_i = 1'($urandom); data_i = PW'({$urandom, $urandom});
      @(posedge clk);
    end
    #1;
    ntests += 3;
    if ({dv_o, hs_o, vs_o} !== 3'b000) begin nfail++; $display("FAIL reset syncs: got %b%b%b want 000", dv_o, hs_o, vs_o); end
    if (win_o !== '0) begin nfail++; $display("FAIL reset win_o: got %h want 0", win_o); end
    if (win_valid_o !== 1'b0) begin nfail++; $display("FAIL reset win_valid: got %b want 0", win_valid_o); end
    rst = 0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      h[i] = 1'($urandom);
      step(h[i], 0, 0, PW'({$urandom, $urandom}));
      ntests++;
      if (dv_o !== (i == 0 ? 1'b0 : h[i-1])) begin
        nfail++; $display("FAIL dv delay step %0d: got %b want %b", i, dv_o, i == 0 ? 1'b0 : h[i-1]);
      end
    end
  endtask
  task automatic test_ramp();
    probe_l = 6; probe_c = 10; snap_hit = 0;
    drive_vs();
    drive_lines(8, SW, 0);
    ntests++;
    if (!snap_hit || snap_v !== 1'b1) begin nfail++; $display("FAIL ramp valid: hit %b got %b want 1", snap_hit, snap_v); end
    for (int r = 0; r < WH; r++)
      for (int k = 0; k < WW; k++) begin
        ntests++;
        if (elem(snap_w, r, k) !== ramp(6 - r, 10 - k)) begin
          nfail++; $display("FAIL ramp [%0d][%0d]: got %h want %h", r, k, elem(snap_w, r, k), ramp(6 - r, 10 - k));
        end
      end
  endtask
  task automatic test_frame_start();
    logic [PW-1:0] b3, b2;
    int early;
    probe_l = 1; probe_c = 5; snap_hit = 0; first_l = -1; first_c = -1;
    for (int i = 0; i < 16; i++) vcnt[i] = 0;
    drive_vs();
    drive_lines(6, SW, 0);
    early = vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3];
`ifdef WINBUF_BORDER_REPLICATE_EN
    b3 = ramp(0, 5); b2 = ramp(0, 4);
`else
    b3 = '0; b2 = '0;
`endif
    ntests += 5;
    if (early != 0) begin nfail++; $display("FAIL early valid count: got %0d want 0", early); end
    if (first_l != 4 || first_c != 2) begin nfail++; $display("FAIL first valid: got (%0d,%0d) want (4,2)", first_l, first_c); end
    if (elem(snap_w, 1, 0) !== ramp(0, 5)) begin nfail++; $display("FAIL row1 at line1: got %h want %h", elem(snap_w, 1, 0), ramp(0, 5)); end
    if (elem(snap_w, 3, 0) !== b3) begin nfail++; $display("FAIL border row3: got %h want %h", elem(snap_w, 3, 0), b3); end
    if (elem(snap_w, 2, 1) !== b2) begin nfail++; $display("FAIL border row2: got %h want %h", elem(snap_w, 2, 1), b2); end
  endtask
  task automatic test_mid_vs();
    drive_lines(3, SW, 0);
    for (int i = 0; i < 16; i++) vcnt[i] = 0;
    drive_vs();
    drive_lines(6, SW, 1);
    ntests += 3;
    if (vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] != 0) begin
      nfail++; $display("FAIL mid vs early valid: got %0d want 0", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3]);
    end
    if (vcnt[4] != SW - WW + 1) begin nfail++; $display("FAIL mid vs line4 valid: got %0d want %0d", vcnt[4], SW - WW + 1); end
    if (vcnt[5] != SW - WW + 1) begin nfail++; $display("FAIL mid vs line5 valid: got %0d want %0d", vcnt[5], SW - WW + 1); end
  endtask
  task automatic test_random();
    drive_vs();
    drive_lines(7, SW, 1);
    drive_vs();
    drive_lines(6, 18, 1);
  endtask
  task automatic test_mid_reset();
    drive_vs();
    drive_lines(2, SW, 0);
    for (int c = 0; c < 9; c++) step(1, 0, 0, ramp(2, c));
    rst = 1; dv_i = 1; data_i = ramp(2, 9);
    @(posedge clk); #1;
    ntests += 3;
    if (win_o !== '0) begin nfail++; $display("FAIL mid reset win_o: got %h want 0", win_o); end
    if (dv_o !== 1'b0) begin nfail++; $display("FAIL mid reset dv_o: got %b want 0", dv_o); end
    if (win_valid_o !== 1'b0) begin nfail++; $display("FAIL mid reset valid: got %b want 0", win_valid_o); end
    rst = 0;
    model_reset();
    for (int c = 10; c < SW; c++) step(1, 0, 0, ramp(2, c));
    for (int b = 0; b < 6; b++) step(0, 0, 0, '0);
    probe_l = 6; probe_c = 10; snap_hit = 0;
    drive_vs();
    drive_lines(7, SW, 0);
    ntests += 2;
    if (!snap_hit || snap_v !== 1'b1) begin nfail++; $display("FAIL recovery valid: hit %b got %b want 1", snap_hit, snap_v); end
    if (elem(snap_w, 4, 2) !== ramp(2, 8)) begin nfail++; $display("FAIL recovery [4][2]: got %h want %h", elem(snap_w, 4, 2), ramp(2, 8)); end
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_frame_start();
    test_mid_vs();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/window_buffer.md
# window_buffer

Streaming 2-D window generator for the video pipeline. It is the multi-line, multi-column, multi-channel successor to the single-column line buffer. It accepts a raster pixel stream with dv/hs/vs and keeps WIN_H-1 lines in block memory. Every valid pixel, it presents a WIN_H x WIN_W neighbourhood to downstream filter kernels, with aligned delayed syncs and a window-valid flag.

## Interface
- COLORDEPTH, 11: bits per colour channel.
- CHANNELS, 1: channels packed per pixel; pixel width PW = CHANNELS*COLORDEPTH.
- SCREENWIDTH, 25: maximum visible pixels per line; line-memory depth.
- WIN_H, 5: window rows (≥2); uses WIN_H-1 line memories.
- WIN_W, 3: window columns (≥1).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- data_i  in  PW  pixel; channel n at [n*COLORDEPTH +: COLORDEPTH].
- dv_i  in  1  data valid (visible pixel).
- hs_i  in  1  horizontal sync, passed through.
- vs_i  in  1  vertical sync, active-high; rising edge = frame start.
- dv_o, hs_o, vs_o  out  1 each  inputs delayed by 2 cycles.
- win_o  out  WIN_H*WIN_W*PW  window, element [r][c] at ((r*WIN_W)+c)*PW; r=0 newest line, c=0 newest pixel.
- win_valid_o  out  1  all window elements come from real pixels of the current frame.

## Operation
- col_cnt (clog2(SCREENWIDTH) bits): 0 while dv_i=0. +1 per dv_i=1 cycle. Wraps to 0 after SCREENWIDTH-1; an over-long line overwrites from address 0.
- line_cnt: cleared on vs_i rising edge. +1 on dv_i falling edge. Saturates at WIN_H-1. A vs_i rise and a dv_i fall in the same cycle → clear wins.
- Line memories L1..L(WIN_H-1), PW x SCREENWIDTH, registered read, no reset.
- Cycle t, dv_i=1: read address col_cnt in all Lk; register data_i, col_cnt and dv_i (stage 1).
- Cycle t+1: column vector v[0]=data_i_d, v[k]=Lk read data. Write L1[addr_d]<=v[0] and Lk[addr_d]<=v[k-1] (cascade).
- Stage 2, on valid stage 1 only: window shifts right one column; column 0 <= v. With dv low, the window holds.
- Rows r > line_cnt are invalid (no line of this frame yet):
  - Without the macro, win_o rows r > line_cnt are forced to 0.
  - With the macro, see Configuration.
- win_valid_o = stage-2 valid AND line_cnt == WIN_H-1 AND stage col index ≥ WIN_W-1.
- Short lines leave the upper addresses unwritten; their stale contents are never marked valid unless line lengths differ, which is unsupported.

## Timing
- Latency 2 cycles: pixel (line l, col c) entering at t appears at win_o[0][0] at t+2, together with dv_o/hs_o/vs_o sampled at t.
- At t+2, win_o[r][k] = pixel (l-r, c-k).
- Centre pixel offset: (WIN_H-1)/2 lines and (WIN_W-1)/2 columns; compensation is downstream's job.
- Throughput: 1 pixel/cycle, no backpressure.
- Reset, effective at the next edge: dv_o/hs_o/vs_o=0, win_o=0, win_valid_o=0, col_cnt=0, line_cnt=0, pipeline valids=0. Memory contents are not cleared.
- Reset mid-frame: outputs go 0. win_valid_o stays 0 until WIN_H-1 full lines after the next vs_i rise.

## Configuration
- WINBUF_BORDER_REPLICATE_EN defined: each invalid row r > line_cnt outputs row line_cnt (clamp to oldest valid line), giving edge replication at the top border.
- Undefined: invalid rows output 0.
- Either way, win_valid_o and the syncs are unaffected.

## Test plan
All scenarios use defaults (COLORDEPTH=11, SCREENWIDTH=25, WIN_H=5, WIN_W=3) driven by vga_timing with the LFSR pixel source.
- Reset: rst for 10 cycles → all outputs 0. After release, dv_o tracks dv_i delayed exactly 2 cycles.
- Ramp data (value = line*32+col): at line 6, col 10 → win_o[r][k] = (6-r)*32+(10-k) at t+2; win_valid_o=1.
- Frame start: lines 0–3 → win_valid_o=0 throughout. Line 4 → win_valid_o first asserts at col 2. Check row forcing: 0 without the macro; row line_cnt replicated with WINBUF_BORDER_REPLICATE_EN.
- Mid-frame vs_i pulse → line_cnt cleared; win_valid_o drops until 4 further full lines have passed.
- CHANNELS=3, distinct per-channel ramps → each channel field of win_o matches its own ramp with no cross-channel mixing.
- rst asserted mid-line → next cycle win_o=0, dv_o=0; recovery after the next vs_i with correct windows.
